forward_scoreboard: RTL and testbench

FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

---
 rtl/forward_scoreboard.sv | 150 +++++++++++++++
 tb/tb_forward_scoreboard.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/forward_scoreboard.sv
// -----------------------------------------------------------------------------
// forward_scoreboard
//
// Tag scoreboard for an in-order pipeline with operand forwarding. For the
// instruction in ID it finds, per source operand, the youngest in-flight
// producer of that register. It then either selects a forwarding stage for
// the next (EX) cycle, or raises a combinational stall while the producer's
// result is not ready yet.
//
// Parameters
//   DEPTH : in-flight tag stages (0 = EX, 1 = MEM, 2 = WB ...), 2..8
//   NSRC  : source operands per instruction
//   AW    : register address width
//   SELW  : derived select width, max(1, clog2(DEPTH))
//
// Ports
//   clk          in   clock, all state on the rising edge
//   rst_n        in   asynchronous active-low reset
//   id_valid     in   instruction present in ID
//   id_src       in   NSRC*AW source addresses, operand k at [k*AW +: AW]
//   id_src_used  in   NSRC per-operand read enables
//   id_we        in   ID instruction writes a register
//   id_rd        in   ID destination register
//   id_lat       in   latency class: result ready leaving stage id_lat
//   flush        in   kill the ID instruction
//   stall        out  hold IF/ID and insert a bubble into EX (combinational)
//   ex_fwd_sel   out  NSRC*SELW registered selects for the EX instruction,
//                     0 = register file, s = forward from stage s
//   stall_cnt    out  16-bit saturating count of stall cycles
//
// Configuration
//   FWD_STALL_CNT_EN : when defined, stall_cnt counts stall cycles; when not
//                      defined stall_cnt is tied to zero and has no flops.
// -----------------------------------------------------------------------------
module forward_scoreboard #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned NSRC  = 2,
    parameter int unsigned AW    = 5,
    localparam int unsigned SELW = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [NSRC*AW-1:0]   id_src,
    input  logic [NSRC-1:0]      id_src_used,
    input  logic                 id_we,
    input  logic [AW-1:0]        id_rd,
    input  logic [1:0]           id_lat,
    input  logic                 flush,
    output logic                 stall,
    output logic [NSRC*SELW-1:0] ex_fwd_sel,
    output logic [15:0]          stall_cnt
);

    typedef struct packed {
        logic          valid;
        logic          we;
        logic [AW-1:0] rd;
        logic [1:0]    lat;
    } tag_t;

    tag_t [DEPTH-1:0]      tag_q;
    logic [NSRC*SELW-1:0]  sel_d;
    logic [NSRC*SELW-1:0]  fwd_sel_q;
    logic                  hazard;
    logic                  issue;
    logic [AW-1:0]         src;
    logic [SELW-1:0]       sel_k;
    logic                  haz_k;

    // -------------------------------------------------------------------------
    // Hazard / select computation for the ID instruction.
    // Entries are scanned oldest to youngest so the youngest match overwrites.
    // The last entry is never searched: by the time a consumer would read it
    // the value has already been written through to the register file.
    // -------------------------------------------------------------------------
    always_comb begin
        sel_d  = '0;
        hazard = 1'b0;
        src    = '0;
        sel_k  = '0;
        haz_k  = 1'b0;
        for (int k = 0; k < int'(NSRC); k++) begin
            src   = id_src[k*AW +: AW];
            sel_k = '0;
            haz_k = 1'b0;
            for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
                if (id_src_used[k] && tag_q[i].valid && tag_q[i].we &&
                    (tag_q[i].rd == src) && (src != '0)) begin
                    sel_k = SELW'(i + 1);
                    // Result is ready only once the producer has left stage lat.
                    haz_k = (int'(tag_q[i].lat) > i);
                end
            end
            sel_d[k*SELW +: SELW] = sel_k;
            hazard = hazard | haz_k;
        end
    end

    // Flush wins over stall: a killed instruction never holds the front end.
    assign stall = id_valid && !flush && hazard;
    assign issue = id_valid && !stall && !flush;

    // -------------------------------------------------------------------------
    // Tag pipeline and registered select.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q     <= '0;
            fwd_sel_q <= '0;
        end else begin
            for (int i = 1; i < int'(DEPTH); i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            if (issue) begin
                tag_q[0]  <= '{valid: 1'b1, we: id_we, rd: id_rd, lat: id_lat};
                fwd_sel_q <= sel_d;
            end else begin
                tag_q[0]  <= '0;
                fwd_sel_q <= '0;
            end
        end
    end

    assign ex_fwd_sel = fwd_sel_q;

    // Oldest entry only exists to model the WB slot; nothing reads it.
    logic unused_tail;
    assign unused_tail = ^tag_q[DEPTH-1];

    // -------------------------------------------------------------------------
    // Optional stall counter.
    // -------------------------------------------------------------------------
`ifdef FWD_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'h0000;
        end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_forward_scoreboard.sv
module tb_forward_scoreboard;

    localparam int unsigned DEPTH = 3;
    localparam int unsigned NSRC  = 2;
    localparam int unsigned AW    = 5;
    localparam int unsigned SELW  = 2;

    logic                 clk;
    logic                 rst_n;
    logic                 id_valid;
    logic [NSRC*AW-1:0]   id_src;
    logic [NSRC-1:0]      id_src_used;
    logic                 id_we;
    logic [AW-1:0]        id_rd;
    logic [1:0]           id_lat;
    logic                 flush;
    logic                 stall;
    logic [NSRC*SELW-1:0] ex_fwd_sel;
    logic [15:0]          stall_cnt;

    int n_cmp;
    int n_fail;
    int exp_cnt;
`ifdef FWD_STALL_CNT_EN
    bit cnt_en = 1'b1;
`else
    bit cnt_en = 1'b0;
`endif

    forward_scoreboard #(
        .DEPTH (DEPTH),
        .NSRC  (NSRC),
        .AW    (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_src      (id_src),
        .id_src_used (id_src_used),
        .id_we       (id_we),
        .id_rd       (id_rd),
        .id_lat      (id_lat),
        .flush       (flush),
        .stall       (stall),
        .ex_fwd_sel  (ex_fwd_sel),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are changed 1 time unit after a rising edge.
    task automatic drive(input logic v, input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                         input logic [1:0] used, input logic we, input logic [AW-1:0] rd,
                         input logic [1:0] lat, input logic fl);
        id_valid    = v;
        id_src      = {s1, s0};
        id_src_used = used;
        id_we       = we;
        id_rd       = rd;
        id_lat      = lat;
        flush       = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_drain();
        drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 2'd0, 1'b0);
        repeat (DEPTH + 1) tick();
    endtask

    task automatic test_reset();
        drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 2'd0, 1'b0);
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %b want 0", stall);
        end
        n_cmp++;
        if (ex_fwd_sel !== 4'b0000) begin
            n_fail++; $display("FAIL reset_sel: got %b want 0000", ex_fwd_sel);
        end
        n_cmp++;
        if (stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
        end
        tick();
        tick();
        rst_n   = 1'b1;
        exp_cnt = 0;
        // First issue after reset must be accepted on the next edge.
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd4, 2'd0, 1'b0);
        tick();
        drive(1'b1, 5'd4, 5'd0, 2'b01, 1'b0, 5'd0, 2'd0, 1'b0);
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL first_issue_stall: got %b want 0", stall);
        end
        tick();
        n_cmp++;
        if (ex_fwd_sel !== 4'b0001) begin
            n_fail++; $display("FAIL first_issue_sel: got %b want 0001", ex_fwd_sel);
        end
        // Asynchronous clear of the registered select, mid-cycle.
        drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 2'd0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ex_fwd_sel !== 4'b0000) begin
            n_fail++; $display("FAIL async_reset_sel: got %b want 0000", ex_fwd_sel);
        end
        rst_n   = 1'b1;
        exp_cnt = 0;
        tick();
    endtask

    task automatic test_alu_fwd();
        idle_drain();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd3, 2'd0, 1'b0);
        tick();
        drive(1'b1, 5'd3, 5'd0, 2'b01, 1'b0, 5'd0, 2'd0, 1'b0);
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL alu_fwd_stall: got %b want 0", stall);
        end
        tick();
        n_cmp++;
        if (ex_fwd_sel !== 4'b0001) begin
            n_fail++; $display("FAIL alu_fwd_sel: got %b want 0001", ex_fwd_sel);
        end
    endtask

    task automatic test_load_use();
        idle_drain();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd5, 2'd1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd5, 2'b10, 1'b0, 5'd0, 2'd0, 1'b0);
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL load_use_stall: got %b want 1", stall);
        end
        tick();
        if (cnt_en) exp_cnt++;
        n_cmp++;
        if (ex_fwd_sel !== 4'b0000) begin
            n_fail++; $display("FAIL load_use_bubble_sel: got %b want 0000", ex_fwd_sel);
        end
        n_cmp++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL load_use_release: got %b want 0", stall);
        end
        n_cmp++;
        if (stall_cnt !== 16'(exp_cnt)) begin
            n_fail++; $display("FAIL load_use_cnt: got %0d want %0d", stall_cnt, exp_cnt);
        end
        tick();
        n_cmp++;
        if (ex_fwd_sel !== 4'b1000) begin
            n_fail++; $display("FAIL load_use_sel: got %b want 1000", ex_fwd_sel);
        end
    endtask

    task automatic test_youngest();
        idle_drain();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd7, 2'd0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd7, 2'd0, 1'b0);
        tick();
        drive(1'b1, 5'd7, 5'd0, 2'b01, 1'b0, 5'd0, 2'd0, 1'b0);
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL youngest_stall: got %b want 0", stall);
        end
        tick();
        n_cmp++;
        if (ex_fwd_sel !== 4'b0001) begin
            n_fail++; $display("FAIL youngest_sel: got %b want 0001", ex_fwd_sel);
        end
    endtask

    task automatic test_r0_unused();
        idle_drain();
        // Load writing r0 is never a dependency.
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd0, 2'd1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 2'b11, 1'b0, 5'd0, 2'd0, 1'b0);
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL r0_stall: got %b want 0", stall);
        end
        tick();
        n_cmp++;
        if (ex_fwd_sel !== 4'b0000) begin
            n_fail++; $display("FAIL r0_sel: got %b want 0000", ex_fwd_sel);
        end
        // Load r9, consumer names r9 on both operands but reads neither.
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd9, 2'd1, 1'b0);
        tick();
        drive(1'b1, 5'd9, 5'd9, 2'b00, 1'b0, 5'd0, 2'd0, 1'b0);
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL unused_stall: got %b want 0", stall);
        end
        tick();
        n_cmp++;
        if (ex_fwd_sel !== 4'b0000) begin
            n_fail++; $display("FAIL unused_sel: got %b want 0000", ex_fwd_sel);
        end
    endtask

    task automatic test_flush();
        idle_drain();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd6, 2'd1, 1'b0);
        tick();
        // Load-use hazard, but flushed; it also claims to write r8.
        drive(1'b1, 5'd6, 5'd0, 2'b01, 1'b1, 5'd8, 2'd0, 1'b1);
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL flush_stall: got %b want 0", stall);
        end
        tick();
        n_cmp++;
        if (ex_fwd_sel !== 4'b0000) begin
            n_fail++; $display("FAIL flush_sel: got %b want 0000", ex_fwd_sel);
        end
        n_cmp++;
        if (stall_cnt !== 16'(exp_cnt)) begin
            n_fail++; $display("FAIL flush_cnt: got %0d want %0d", stall_cnt, exp_cnt);
        end
        // If the flushed instruction had entered EX, r8 would forward from stage 1.
        drive(1'b1, 5'd8, 5'd0, 2'b01, 1'b0, 5'd0, 2'd0, 1'b0);
        tick();
        n_cmp++;
        if (ex_fwd_sel !== 4'b0000) begin
            n_fail++; $display("FAIL flush_bubble: got %b want 0000", ex_fwd_sel);
        end
    endtask

    task automatic test_back_to_back();
        idle_drain();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd1, 2'd0, 1'b0);
        tick();
        drive(1'b1, 5'd1, 5'd0, 2'b01, 1'b1, 5'd2, 2'd0, 1'b0);
        tick();
        n_cmp++;
        if (ex_fwd_sel !== 4'b0001) begin
            n_fail++; $display("FAIL b2b_sel_a: got %b want 0001", ex_fwd_sel);
        end
        drive(1'b1, 5'd1, 5'd2, 2'b11, 1'b1, 5'd3, 2'd0, 1'b0);
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL b2b_stall: got %b want 0", stall);
        end
        tick();
        n_cmp++;
        if (ex_fwd_sel !== 4'b0110) begin
            n_fail++; $display("FAIL b2b_sel_b: got %b want 0110", ex_fwd_sel);
        end
    endtask

    task automatic test_stall_cnt();
        idle_drain();
        rst_n = 1'b0;
        #1;
        rst_n   = 1'b1;
        exp_cnt = 0;
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'(10 + j), 2'd1, 1'b0);
            tick();
            drive(1'b1, 5'(10 + j), 5'd0, 2'b01, 1'b0, 5'd0, 2'd0, 1'b0);
            #1;
            n_cmp++;
            if (stall !== 1'b1) begin
                n_fail++; $display("FAIL cnt_stall_%0d: got %b want 1", j, stall);
            end
            tick();
            if (cnt_en) exp_cnt++;
            tick();
        end
        drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd14, 2'd1, 1'b0);
        tick();
        drive(1'b1, 5'd14, 5'd0, 2'b01, 1'b0, 5'd0, 2'd0, 1'b0);
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL cnt_stall_4th: got %b want 1", stall);
        end
        n_cmp++;
        if (stall_cnt !== 16'(exp_cnt)) begin
            n_fail++; $display("FAIL cnt_three: got %0d want %0d", stall_cnt, exp_cnt);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL cnt_async_clear: got %0d want 0", stall_cnt);
        end
        n_cmp++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL cnt_reset_stall: got %b want 0", stall);
        end
        rst_n   = 1'b1;
        exp_cnt = 0;
        drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 2'd0, 1'b0);
        tick();
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        exp_cnt = 0;
        rst_n   = 1'b0;
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_youngest();
        test_r0_unused();
        test_flush();
        test_back_to_back();
        test_stall_cnt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
